// File: rtl/shift_pkg.sv
// Shared definitions for the iterative address shifter: direction codes and FSM states.
package shift_pkg;

  localparam logic LEFT_SHIFT  = 1'b0;
  localparam logic RIGHT_SHIFT = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/addr_shift_seq_shift1.sv
// Combinational single-position shifter; ADDR_SHIFT_ROTATE_EN turns each step into a rotate.
module shift1
  import shift_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] address,
  input  logic             dir,
  output logic [WIDTH-1:0] result
);

  // Select the one-bit move for the requested direction
  always_comb begin
    result = address;
    if (dir == RIGHT_SHIFT) begin
`ifdef ADDR_SHIFT_ROTATE_EN
      result = {address[0], address[WIDTH-1:1]};
`else
      result = {1'b0, address[WIDTH-1:1]};
`endif
    end else begin
`ifdef ADDR_SHIFT_ROTATE_EN
      result = {address[WIDTH-2:0], address[WIDTH-1]};
`else
      result = {address[WIDTH-2:0], 1'b0};
`endif
    end
  end

endmodule

// File: rtl/addr_shift_seq.sv
// Iterative multi-bit address shifter: one single-bit step per clock between two valid/ready handshakes.
// Optional rotate mode via ADDR_SHIFT_ROTATE_EN (implemented in shift1).
module addr_shift_seq
  import shift_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int AMT_W = 5
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_addr,
  input  logic             in_dir,
  input  logic [AMT_W-1:0] in_amt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_addr,
  output logic             out_dir
);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   work_q, work_d;
  logic               dir_q, dir_d;
  logic [AMT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   step_s;

  shift1 #(.WIDTH(WIDTH)) u_shift1 (
    .address (work_q),
    .dir     (dir_q),
    .result  (step_s)
  );

  // Next-state and datapath update
  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    dir_d   = dir_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          work_d  = in_addr;
          dir_d   = in_dir;
          cnt_d   = in_amt;
          state_d = (in_amt == {AMT_W{1'b0}}) ? DONE : SHIFT;
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        work_d = step_s;
        cnt_d  = cnt_q - {{(AMT_W-1){1'b0}}, 1'b1};
        // Last step when this cycle's shift consumes the final count
        if (cnt_q == {{(AMT_W-1){1'b0}}, 1'b1}) begin
          state_d = DONE;
        end else begin
          state_d = SHIFT;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and working registers with synchronous active-low reset
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= IDLE;
      work_q  <= {WIDTH{1'b0}};
      dir_q   <= 1'b0;
      cnt_q   <= {AMT_W{1'b0}};
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      dir_q   <= dir_d;
      cnt_q   <= cnt_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign out_addr  = work_q;
  assign out_dir   = dir_q;

endmodule
